// File: rtl/irq_seq.sv
// irq_seq: interrupt entry/exit sequencer.
// Watches a level IRQ line through a synchronizer. At an instruction boundary
// in IDLE it either starts the exception-return restore or runs the fixed
// entry sequence. The entry sequence is flush, then PSR backup with the LR write,
// then the PC load to the IRQ vector. All outputs are decoded from the state
// register only.
//
// Advance semantics: `en` is the single pipeline-advance qualifier. A state
// and its strobes are presented every cycle. The downstream blocks consume
// them on a rising edge with en=1. The sequencer moves to the next state on
// that same edge. With en=0 the strobes are re-presented unchanged, and no
// register except the IRQ synchronizer changes.
module irq_seq #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] IRQ_VECTOR  = 32'h0000_0018,
    parameter logic [31:0] LR_OFFSET   = 32'd4,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             i_irq,
    input  logic             i_irq_mask,
    input  logic             i_int_mode,
    input  logic             i_insn_boundary,
    input  logic [31:0]      i_pc_next,
    input  logic             i_eret,
    output logic             o_stall,
    output logic             o_flush,
    output logic             o_spsr_bak,
    output logic             o_spsr_res,
    output logic             o_lr_wr,
    output logic [31:0]      o_lr_data,
    output logic             o_pc_load,
    output logic [31:0]      o_pc_target,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_irq_cnt
);

    // State encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_TAKE   = 3'd1;
    localparam logic [2:0] ST_SAVE   = 3'd2;
    localparam logic [2:0] ST_JUMP   = 3'd3;
    localparam logic [2:0] ST_RETURN = 3'd4;

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   irq_s;

    logic [2:0]             state_q;
    logic [2:0]             state_d;
    logic [31:0]            ret_pc_q;
    logic [31:0]            ret_pc_d;
    logic [CNT_W-1:0]       irq_cnt_q;
    logic [CNT_W-1:0]       irq_cnt_d;

    logic                   eret_at_boundary;
    logic                   irq_qualified;

    // Synchronizer shift: new sample enters at bit 0, irq_s is the oldest stage
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_irq};
    end

    // Synchronizer flops run every cycle, independent of en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign irq_s = sync_q[SYNC_STAGES-1];

    // Exception return wins over a pending IRQ at the same boundary
    assign eret_at_boundary = i_insn_boundary & i_eret;
    assign irq_qualified    = i_insn_boundary & irq_s & ~i_irq_mask & ~i_int_mode;

    // Next-state, return-PC capture and taken-interrupt count
    always_comb begin
        state_d   = state_q;
        ret_pc_d  = ret_pc_q;
        irq_cnt_d = irq_cnt_q;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (eret_at_boundary) begin
                        state_d = ST_RETURN;
                    end else if (irq_qualified) begin
                        state_d  = ST_TAKE;
                        ret_pc_d = i_pc_next;
                    end
                end
                ST_TAKE: begin
                    state_d = ST_SAVE;
                end
                ST_SAVE: begin
                    state_d = ST_JUMP;
                end
                ST_JUMP: begin
                    // The PC load commits on this edge, so the entry is counted here
                    state_d   = ST_IDLE;
                    irq_cnt_d = irq_cnt_q + CNT_W'(1);
                end
                ST_RETURN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer registers; async reset drops any partial sequence at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            ret_pc_q  <= '0;
            irq_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            ret_pc_q  <= ret_pc_d;
            irq_cnt_q <= irq_cnt_d;
        end
    end

    // Moore output decode: strobes depend on the state register only
    always_comb begin
        o_stall    = 1'b0;
        o_flush    = 1'b0;
        o_spsr_bak = 1'b0;
        o_spsr_res = 1'b0;
        o_lr_wr    = 1'b0;
        o_pc_load  = 1'b0;
        case (state_q)
            ST_TAKE: begin
                o_stall = 1'b1;
                o_flush = 1'b1;
            end
            ST_SAVE: begin
                o_stall    = 1'b1;
                o_spsr_bak = 1'b1;
                o_lr_wr    = 1'b1;
            end
            ST_JUMP: begin
                o_stall   = 1'b1;
                o_pc_load = 1'b1;
            end
            ST_RETURN: begin
                o_stall    = 1'b1;
                o_spsr_res = 1'b1;
            end
            default: begin
                o_stall = 1'b0;
            end
        endcase
    end

    // Data outputs are valid in every state; only the strobes qualify them
    assign o_lr_data   = ret_pc_q + LR_OFFSET;
    assign o_pc_target = IRQ_VECTOR;
    assign o_busy      = (state_q != ST_IDLE);
    assign o_irq_cnt   = irq_cnt_q;

endmodule
